// File: rtl/linked_list_reader_if.sv
// Push/pop handshake between the linked-list pointer manager, the data store
// writer, the reader and the downstream consumer.
interface linked_list_reader_if #(
  parameter int NUM_ELEMS  = 4,
  parameter int NUM_LISTS  = 2,
  parameter int DATA_WIDTH = 8,
  parameter int PTR_WIDTH  = $clog2(NUM_ELEMS),
  parameter int LIST_W     = (NUM_LISTS > 1) ? $clog2(NUM_LISTS) : 1
);
  logic                  wr_en;
  logic [PTR_WIDTH-1:0]  wr_ptr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [NUM_LISTS-1:0]  empty;
  logic [NUM_LISTS-1:0]  list_en;
  logic [PTR_WIDTH-1:0]  popped_head;
  logic [NUM_LISTS-1:0]  pop;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic [LIST_W-1:0]     out_list;

  modport slave (
    input  wr_en, wr_ptr, wr_data, empty, list_en, popped_head, out_ready,
    output pop, out_valid, out_data, out_list
  );

  modport master (
    output wr_en, wr_ptr, wr_data, empty, list_en, popped_head, out_ready,
    input  pop, out_valid, out_data, out_list
  );
endinterface

// File: rtl/linked_list_reader.sv
// Round-robin reader over several linked lists sharing one data store; pops
// one head per cycle into a single-entry output register.
module linked_list_reader #(
  parameter int NUM_ELEMS  = 4,
  parameter int NUM_LISTS  = 2,
  parameter int DATA_WIDTH = 8,
  parameter int PTR_WIDTH  = $clog2(NUM_ELEMS),
  parameter int LIST_W     = (NUM_LISTS > 1) ? $clog2(NUM_LISTS) : 1
) (
  input logic                  clk,
  input logic                  rst,
  linked_list_reader_if.slave  bus
);

  logic [DATA_WIDTH-1:0] mem_q [NUM_ELEMS];

  logic [LIST_W-1:0]     rr_q, rr_d;
  logic [LIST_W-1:0]     grant;
  logic                  found;
  logic                  slot_free;
  logic                  pop_any;
  logic [NUM_LISTS-1:0]  elig;
  logic [DATA_WIDTH-1:0] pop_data;

  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q,  out_data_d;
  logic [LIST_W-1:0]     out_list_q,  out_list_d;

  always_ff @(posedge clk) begin
    if (bus.wr_en) mem_q[bus.wr_ptr] <= bus.wr_data;
  end

  assign elig      = ~bus.empty & bus.list_en;
  assign slot_free = !out_valid_q || bus.out_ready;

  // Scan from the far end back to rr_q so the last hit is the first eligible.
  always_comb begin
    int k;
    logic [LIST_W-1:0] kk;
    grant = '0;
    found = 1'b0;
    k     = 0;
    kk    = '0;
    for (int i = NUM_LISTS - 1; i >= 0; i--) begin
      k = int'(rr_q) + i;
      if (k >= NUM_LISTS) k = k - NUM_LISTS;
      kk = LIST_W'(k);
      if (elig[kk]) begin
        grant = kk;
        found = 1'b1;
      end
    end
  end

  assign pop_any = found && slot_free && !rst;
  assign bus.pop = pop_any ? (NUM_LISTS'(1) << grant) : '0;

  // A write landing on the head being popped this cycle wins over the stale entry.
  assign pop_data = (bus.wr_en && (bus.wr_ptr == bus.popped_head)) ?
                    bus.wr_data : mem_q[bus.popped_head];

  always_comb begin
    int n;
    rr_d        = rr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_list_d  = out_list_q;
    n           = 0;
    if (pop_any) begin
      n = int'(grant) + 1;
      if (n >= NUM_LISTS) n = 0;
      rr_d        = LIST_W'(n);
      out_valid_d = 1'b1;
      out_data_d  = pop_data;
      out_list_d  = grant;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q        <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_list_q  <= '0;
    end else begin
      rr_q        <= rr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_list_q  <= out_list_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_list  = out_list_q;

endmodule

// File: doc/linked_list_reader.md
LINKED_LIST_READER -- requirements
Module: linked_list_reader

Interface
REQ-001 Parameter NUM_ELEMS, default 4, total shared-memory entries (matches the pointer manager).
REQ-002 Parameter NUM_LISTS, default 2, number of lists served; NUM_LISTS <= NUM_ELEMS.
REQ-003 Parameter DATA_WIDTH, default 8, payload width per entry.
REQ-004 Parameter PTR_WIDTH, default $clog2(NUM_ELEMS), pointer width.
REQ-005 clk  input  1  single clock; all state updates on posedge clk.
REQ-006 rst  input  1  reset, synchronous and active-high.
REQ-007 wr_en  input  1  write strobe into the data store (push side).
REQ-008 wr_ptr  input  PTR_WIDTH  write address; the pointer manager's free_ptr.
REQ-009 wr_data  input  DATA_WIDTH  payload written at wr_ptr.
REQ-010 empty  input  NUM_LISTS  per-list empty flags from the pointer manager.
REQ-011 list_en  input  NUM_LISTS  per-list service enable; 0 excludes that list from arbitration.
REQ-012 popped_head  input  PTR_WIDTH  head pointer of the list selected by pop, valid in the same cycle.
REQ-013 pop  output  NUM_LISTS  zero or one-hot pop request to the pointer manager.
REQ-014 out_valid  output  1  output register holds an entry.
REQ-015 out_ready  input  1  downstream accepts; transfer when out_valid & out_ready.
REQ-016 out_data  output  DATA_WIDTH  dequeued payload.
REQ-017 out_list  output  $clog2(NUM_LISTS) (min 1)  index of the list the payload came from.

Function
REQ-018 Data store: NUM_ELEMS x DATA_WIDTH array; on wr_en, data[wr_ptr] <= wr_data at posedge; no reset of contents.
REQ-019 Eligible list k: !empty[k] & list_en[k].
REQ-020 slot_free = !out_valid | out_ready (combinational).
REQ-021 pop is combinational: one-hot on the granted list when slot_free and at least one list is eligible, else all zero; never more than one bit set; never set for an ineligible list.
REQ-022 Arbitration: round-robin starting at rr_ptr; grant = first eligible index in rr_ptr, rr_ptr+1, ... wrapping modulo NUM_LISTS.
REQ-023 On a cycle with pop != 0, rr_ptr <= (granted index + 1) mod NUM_LISTS; otherwise rr_ptr holds.
REQ-024 On a pop cycle, at posedge: out_data <= data[popped_head], out_list <= granted index, out_valid <= 1; latency pop-to-out_valid = 1 cycle.
REQ-025 Bypass: if wr_en and wr_ptr == popped_head in a pop cycle, out_data captures wr_data.
REQ-026 No pop cycle and out_valid & out_ready: out_valid <= 0; out_data/out_list hold.
REQ-027 out_valid & !out_ready: out_valid, out_data, and out_list hold; pop stays 0 (backpressure).
REQ-028 Simultaneous transfer and pop: output register reloads in the same edge; full throughput of one entry per cycle.
REQ-029 All lists empty or disabled: pop = 0, rr_ptr holds.
REQ-030 Pointer wrap: rr_ptr wraps NUM_LISTS-1 -> 0; NUM_LISTS=1 degenerates to a fixed grant of list 0.

Reset
REQ-031 On rst: out_valid = 0, out_data = 0, out_list = 0, rr_ptr = 0; pop = 0 during any rst cycle.
REQ-032 rst mid-operation discards the held output entry; an element popped in the rst cycle is not issued (pop forced 0).

Verification
REQ-033 Reset, then empty=2'b10, list_en=2'b11, data[3]=8'hA5 preloaded, popped_head=3, out_ready=1 -> pop=2'b01 in cycle 0; cycle 1 out_valid=1, out_data=8'hA5, out_list=0.
REQ-034 Both lists non-empty, out_ready=1 for 4 cycles -> pop sequence 01,10,01,10; out_list sequence 0,1,0,1.
REQ-035 out_valid=1, out_ready=0 for 3 cycles with lists non-empty -> pop=0 throughout; out_data/out_list stable; pop resumes the cycle out_ready=1.
REQ-036 list_en=2'b01, both lists non-empty -> only pop=2'b01 ever asserted; rr_ptr wraps to 1 then grants list 0.
REQ-037 wr_en=1, wr_ptr=2, wr_data=8'h3C, and a pop with popped_head=2 in the same cycle -> next cycle out_data=8'h3C.
REQ-038 rst asserted while out_valid=1 -> next cycle out_valid=0, pop=0 during rst, rr_ptr=0 after release.
